// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n},
// controller state enumeration and default timing constants (100 MHz).
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam int unsigned DEF_ADDR_W      = 12;
  localparam int unsigned DEF_T_PWR       = 10000;
  localparam int unsigned DEF_T_RP        = 2;
  localparam int unsigned DEF_T_RC        = 7;
  localparam int unsigned DEF_T_MRD       = 3;
  localparam int unsigned DEF_INIT_AR_NUM = 8;
  localparam int unsigned DEF_REF_AR_NUM  = 1;
  localparam int unsigned DEF_T_REFI      = 750;
  localparam logic [11:0] DEF_MODE_REG    = 12'h033;

  typedef enum logic [3:0] {
    S_PWR, S_PRE, S_TRP, S_AREF, S_TRC, S_MRS, S_TMRD, S_IDLE,
    S_RPRE, S_RTRP, S_RAREF, S_RTRC
  } state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// Loadable down-counter. done_o pulses in the cycle the count reaches zero,
// near_o pulses one cycle earlier. A load value of 0 gives done_o in the
// load cycle itself. Comes out of reset already loaded with RST_VAL.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i, val_i : load request and value
//   near_o, done_o: registered pulses
module sdram_wait_cnt #(
  parameter int unsigned W       = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         near_o,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         near_q, near_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= W'(RST_VAL);
      done_q <= 1'b0;
      near_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      near_q <= near_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    near_d = 1'b0;
    if (load_i) begin
      cnt_d  = val_i;
      done_d = (val_i == '0);
      near_d = (val_i == W'(1));
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - W'(1);
      done_d = (cnt_q == W'(1));
      near_d = (cnt_q == W'(2));
    end
  end

  assign done_o = done_q;
  assign near_o = near_q;

endmodule

// File: rtl/sdram_ctrl_init_ref.sv
// SDRAM power-up initialisation and periodic auto-refresh engine.
//   sys_clk, sys_rst_n      : clock, async active-low reset
//   cmd_reg                 : {cs_n,ras_n,cas_n,we_n}
//   sdram_bank, sdram_addr  : bank / address bus
//   flag_init_end           : sticky init-complete flag
//   ref_req / ref_en        : refresh request / arbiter grant
//   ref_busy, ref_end       : refresh in progress / last-cycle pulse
//   ref_miss                : sticky, a refresh period expired unserved
module sdram_ctrl_init_ref
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned T_PWR       = DEF_T_PWR,
  parameter int unsigned T_RP        = DEF_T_RP,
  parameter int unsigned T_RC        = DEF_T_RC,
  parameter int unsigned T_MRD       = DEF_T_MRD,
  parameter int unsigned INIT_AR_NUM = DEF_INIT_AR_NUM,
  parameter int unsigned REF_AR_NUM  = DEF_REF_AR_NUM,
  parameter int unsigned T_REFI      = DEF_T_REFI,
  parameter logic [11:0] MODE_REG    = DEF_MODE_REG
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic [3:0]        cmd_reg,
  output logic [1:0]        sdram_bank,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              flag_init_end,
  output logic              ref_req,
  input  logic              ref_en,
  output logic              ref_busy,
  output logic              ref_end,
  output logic              ref_miss
);

  localparam int unsigned T_MAX  = max2(max2(T_PWR, T_RP), max2(T_RC, T_MRD));
  localparam int unsigned CNT_W  = $clog2(T_MAX + 1);
  localparam int unsigned AR_W   = $clog2(max2(INIT_AR_NUM, REF_AR_NUM) + 1);
  localparam int unsigned REFI_W = $clog2(T_REFI + 1);
  // Waits are loaded one short: the counter's done cycle is the cycle in
  // which the FSM registers the next command.
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RC  = CNT_W'(T_RC - 1);
  localparam logic [CNT_W-1:0] LD_MRD = CNT_W'(T_MRD - 1);
  localparam logic             RC_ONE = (T_RC <= 1);

  state_e              state_q, state_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [1:0]          bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                flag_q, flag_d;
  logic                busy_q, busy_d;
  logic                end_q, end_d;
  logic [AR_W-1:0]     ar_q, ar_d;
  logic                req_q, req_d;
  logic                miss_q, miss_d;
  logic [REFI_W-1:0]   refi_q, refi_d;
  logic                wait_load;
  logic [CNT_W-1:0]    wait_val;
  logic                wait_near, wait_done;
  logic                grant, wrap;

  // Power-up wait starts preloaded so the first PRE lands in cycle T_PWR.
  sdram_wait_cnt #(.W(CNT_W), .RST_VAL(T_PWR)) u_wait (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .load_i (wait_load),
    .val_i  (wait_val),
    .near_o (wait_near),
    .done_o (wait_done)
  );

  assign grant = (state_q == S_IDLE) && req_q && ref_en;
  assign wrap  = flag_q && (refi_q == REFI_W'(T_REFI - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_PWR;
      cmd_q   <= CMD_NOP;
      bank_q  <= 2'b11;
      addr_q  <= '1;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      ar_q    <= '0;
      req_q   <= 1'b0;
      miss_q  <= 1'b0;
      refi_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
      ar_q    <= ar_d;
      req_q   <= req_d;
      miss_q  <= miss_d;
      refi_q  <= refi_d;
    end
  end

  // Free-running refresh interval timer; a grant coinciding with a wrap
  // consumes the old request while the wrap raises a new one.
  always_comb begin
    refi_d = refi_q;
    if (flag_q) refi_d = wrap ? '0 : refi_q + REFI_W'(1);
    req_d = req_q;
    if (wrap)       req_d = 1'b1;
    else if (grant) req_d = 1'b0;
    miss_d = miss_q | (wrap & req_q & ~grant);
  end

  // Command sequencer. PRE keeps addr all ones, which sets A10 (all banks).
  always_comb begin
    state_d   = state_q;
    cmd_d     = CMD_NOP;
    bank_d    = 2'b11;
    addr_d    = '1;
    flag_d    = flag_q;
    busy_d    = busy_q;
    end_d     = 1'b0;
    ar_d      = ar_q;
    wait_load = 1'b0;
    wait_val  = '0;
    case (state_q)
      S_PWR: begin
        if (wait_done) begin
          state_d = S_PRE; cmd_d = CMD_PRE;
          wait_load = 1'b1; wait_val = LD_RP;
        end
      end
      S_PRE, S_TRP: begin
        if (wait_done) begin
          state_d = S_AREF; cmd_d = CMD_AREF; ar_d = AR_W'(1);
          wait_load = 1'b1; wait_val = LD_RC;
        end else state_d = S_TRP;
      end
      S_AREF, S_TRC: begin
        if (!wait_done) state_d = S_TRC;
        else if (ar_q == AR_W'(INIT_AR_NUM)) begin
          state_d = S_MRS; cmd_d = CMD_MRS;
          bank_d = 2'b00; addr_d = ADDR_W'(MODE_REG);
          wait_load = 1'b1; wait_val = LD_MRD;
        end else begin
          state_d = S_AREF; cmd_d = CMD_AREF; ar_d = ar_q + AR_W'(1);
          wait_load = 1'b1; wait_val = LD_RC;
        end
      end
      S_MRS, S_TMRD: begin
        if (wait_done) begin
          state_d = S_IDLE; flag_d = 1'b1;
        end else state_d = S_TMRD;
      end
      S_IDLE: begin
        if (grant) begin
          state_d = S_RPRE; cmd_d = CMD_PRE; busy_d = 1'b1;
          wait_load = 1'b1; wait_val = LD_RP;
        end
      end
      S_RPRE, S_RTRP: begin
        if (wait_done) begin
          state_d = S_RAREF; cmd_d = CMD_AREF; ar_d = AR_W'(1);
          wait_load = 1'b1; wait_val = LD_RC;
          end_d = RC_ONE && (REF_AR_NUM == 1);
        end else state_d = S_RTRP;
      end
      S_RAREF, S_RTRC: begin
        // ref_end is registered, so it is raised from the near pulse.
        end_d = wait_near && (ar_q == AR_W'(REF_AR_NUM));
        if (!wait_done) state_d = S_RTRC;
        else if (ar_q == AR_W'(REF_AR_NUM)) begin
          state_d = S_IDLE; busy_d = 1'b0;
        end else begin
          state_d = S_RAREF; cmd_d = CMD_AREF; ar_d = ar_q + AR_W'(1);
          wait_load = 1'b1; wait_val = LD_RC;
          end_d = RC_ONE && ((ar_q + AR_W'(1)) == AR_W'(REF_AR_NUM));
        end
      end
      default: state_d = S_PWR;
    endcase
  end

  assign cmd_reg       = cmd_q;
  assign sdram_bank    = bank_q;
  assign sdram_addr    = addr_q;
  assign flag_init_end = flag_q;
  assign ref_req       = req_q;
  assign ref_busy      = busy_q;
  assign ref_end       = end_q;
  assign ref_miss      = miss_q;

endmodule

// File: doc/sdram_ctrl_init_ref.md
Name: sdram_ctrl_init_ref

Overview:
Parametrised SDRAM power-up initialisation and auto-refresh engine. It drives the SDRAM command bus through the JEDEC init sequence: power-up wait, precharge-all, N auto-refreshes, then load-mode-register. After init it schedules periodic auto-refresh through a request/grant handshake with the future read/write arbiter. It sits between sdram_top's command mux and the SDRAM pins.

Parameters:
ADDR_W, 12, SDRAM address bus width (>=11; A10 is the precharge-all bit)
T_PWR, 10000, power-up NOP cycles after reset release (100 us at 100 MHz)
T_RP, 2, precharge-to-next-command cycles
T_RC, 7, auto-refresh-to-next-command cycles
T_MRD, 3, mode-register-set-to-ready cycles
INIT_AR_NUM, 8, auto-refresh commands issued during init (>=2)
REF_AR_NUM, 1, auto-refresh commands per periodic refresh (>=1)
T_REFI, 750, cycles between refresh requests (7.5 us at 100 MHz)
MODE_REG, 12'h033, value driven on addr during MRS (CL3, sequential, BL8); zero-extended to ADDR_W

Ports:
sys_clk  in  1  system clock, all logic rising-edge
sys_rst_n  in  1  asynchronous active-low reset
cmd_reg  out  4  {cs_n,ras_n,cas_n,we_n}
sdram_bank  out  2  bank address
sdram_addr  out  ADDR_W  address bus
flag_init_end  out  1  high once init completes; sticky until reset
ref_req  out  1  refresh request to arbiter
ref_en  in  1  arbiter grant; sampled only while ref_req=1
ref_busy  out  1  high from grant cycle until the refresh sequence completes
ref_end  out  1  one-cycle pulse on the last cycle of a refresh sequence
ref_miss  out  1  sticky: a T_REFI period expired while a request was still pending

Behaviour:
- Commands: NOP=0111, PRE=0010, AREF=0001, MRS=0000. All outputs registered.
- Reset values: cmd_reg=NOP, sdram_bank=2'b11, sdram_addr=all ones, all flags 0. Assertion mid-operation aborts any sequence immediately. Deassertion restarts from the power-up wait.
- Timing rule: each command is driven for exactly one cycle, then NOP. The next command issues exactly T_x cycles after the previous one.
- FSM states: S_PWR, S_PRE, S_TRP, S_AREF, S_TRC, S_MRS, S_TMRD, S_IDLE, S_RPRE, S_RTRP, S_RAREF, S_RTRC.
- Init sequence:
  - S_PWR counts T_PWR cycles; PRE is issued in cycle T_PWR after reset release (cycle 0 = first edge with rst_n high).
  - PRE: addr[10]=1, bank=11. S_TRP waits T_RP.
  - AREF then S_TRC, repeated INIT_AR_NUM times, using a separate AR counter.
  - MRS: bank=00, addr=MODE_REG. S_TMRD waits T_MRD.
  - flag_init_end goes high in the cycle after the wait, then enter S_IDLE.
- Refresh timer:
  - Counter 0..T_REFI-1, starting the cycle flag_init_end rises and running free (never paused).
  - Wrap sets ref_req.
  - A wrap while ref_req is still set sets ref_miss; ref_req remains a single request (no queueing).
  - Wrap and grant in the same cycle: the grant is taken, ref_req stays set for the new period, no miss.
- Handshake:
  - In S_IDLE with ref_req=1 and ref_en=1: ref_req clears next cycle, ref_busy sets, sequence PRE→T_RP→(AREF→T_RC)×REF_AR_NUM starts.
  - ref_en is ignored when ref_req=0 or outside S_IDLE.
  - ref_end pulses on the final T_RC cycle; ref_busy drops the cycle after, with a return to S_IDLE.
- Outside PRE and MRS cycles, addr=all ones and bank=11.

Decomposition:
- Package sdram_pkg: command localparams (CMD_NOP, CMD_PRE, CMD_AREF, CMD_MRS, plus CMD_ACT/RD/WR for later blocks), state enumeration, and default timing constants shared with future read/write modules.
- One sub-module, sdram_wait_cnt: loadable down-counter with a done pulse, reused for T_PWR, T_RP, T_RC and T_MRD. The refresh interval timer stays inline.

Test Plan:
- Scenario params: T_PWR=20, T_RP=2, T_RC=4, T_MRD=2, INIT_AR_NUM=2, REF_AR_NUM=1, T_REFI=50.
- Init timing: release reset at cycle 0 → PRE at cycle 20 (addr[10]=1), AREF at 22 and 26, MRS at 30 (addr=12'h033, bank=00), flag_init_end=1 from cycle 32; NOP everywhere else.
- Refresh request and grant: with no grant, ref_req rises at cycle 82. Grant at 85 → ref_req=0 at 86; PRE at 86, AREF at 88, ref_end pulse at 91, ref_busy high 86..91.
- Missed refresh: hold ref_en=0 through cycle 132 → ref_miss=1 at 132 and sticky, ref_req stays 1. Later grant → exactly one refresh sequence.
- Wrap/grant collision: grant in the same cycle as the wrap → refresh executes, ref_req remains 1, ref_miss stays 0.
- Reset mid-sequence: assert sys_rst_n=0 during the init AREF at cycle 26 → outputs return to reset values asynchronously. Release → PRE again 20 cycles later; flag_init_end=0 until the sequence completes.
- Spurious grant: ref_en=1 during init and while ref_req=0 → no command issued, no state change.
